// File: rtl/multicycle_control.sv
// Multi-cycle control unit: walks each instruction through
// FETCH/DECODE/EXECUTE/MEM/WRITEBACK and drives the datapath enables and
// mux selects. Memory accesses stall on mem_ready with a bounded wait.
// The unit halts on SYSCALL, on an illegal opcode or on a memory timeout.
// Control outputs are combinational from state/opcode/func and are forced
// to their reset values while rst is high.
module multicycle_control #(
    parameter int OPCODE_LENGTH = 6,
    parameter int FUNCT_LENGTH  = 6,
    parameter int MEM_TIMEOUT   = 15,
    parameter int TIMER_WIDTH   = 8
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic [OPCODE_LENGTH-1:0] opcode,
    input  logic [FUNCT_LENGTH-1:0]  func,
    input  logic                     mem_ready,
    output logic                     mem_req,
    output logic                     ir_write,
    output logic                     pc_write,
    output logic                     reg_dst,
    output logic                     mem_to_reg,
    output logic                     reg_write,
    output logic                     mem_read,
    output logic                     mem_write,
    output logic                     jr,
    output logic                     do_extend,
    output logic                     is_LB_SB,
    output logic [1:0]               alu_src,
    output logic [3:0]               alu_op,
    output logic [2:0]               branch,
    output logic [1:0]               jump,
    output logic                     halted,
    output logic [1:0]               fault,
    output logic [2:0]               state
);

    typedef enum logic [2:0] {
        S_FETCH     = 3'd0,
        S_DECODE    = 3'd1,
        S_EXECUTE   = 3'd2,
        S_MEM       = 3'd3,
        S_WRITEBACK = 3'd4,
        S_HALT      = 3'd5
    } state_t;

    localparam logic [1:0] FLT_NONE    = 2'b00;
    localparam logic [1:0] FLT_ILLEGAL = 2'b01;
    localparam logic [1:0] FLT_TIMEOUT = 2'b10;

    // Opcodes
    localparam logic [OPCODE_LENGTH-1:0] OP_RTYPE = OPCODE_LENGTH'(6'b000000);
    localparam logic [OPCODE_LENGTH-1:0] OP_J     = OPCODE_LENGTH'(6'b000010);
    localparam logic [OPCODE_LENGTH-1:0] OP_JAL   = OPCODE_LENGTH'(6'b000011);
    localparam logic [OPCODE_LENGTH-1:0] OP_BEQ   = OPCODE_LENGTH'(6'b000100);
    localparam logic [OPCODE_LENGTH-1:0] OP_BNE   = OPCODE_LENGTH'(6'b000101);
    localparam logic [OPCODE_LENGTH-1:0] OP_BLEZ  = OPCODE_LENGTH'(6'b000110);
    localparam logic [OPCODE_LENGTH-1:0] OP_BGTZ  = OPCODE_LENGTH'(6'b000111);
    localparam logic [OPCODE_LENGTH-1:0] OP_ADDI  = OPCODE_LENGTH'(6'b001000);
    localparam logic [OPCODE_LENGTH-1:0] OP_ADDIU = OPCODE_LENGTH'(6'b001001);
    localparam logic [OPCODE_LENGTH-1:0] OP_SLTI  = OPCODE_LENGTH'(6'b001010);
    localparam logic [OPCODE_LENGTH-1:0] OP_ANDI  = OPCODE_LENGTH'(6'b001100);
    localparam logic [OPCODE_LENGTH-1:0] OP_ORI   = OPCODE_LENGTH'(6'b001101);
    localparam logic [OPCODE_LENGTH-1:0] OP_XORI  = OPCODE_LENGTH'(6'b001110);
    localparam logic [OPCODE_LENGTH-1:0] OP_LUI   = OPCODE_LENGTH'(6'b001111);
    localparam logic [OPCODE_LENGTH-1:0] OP_LB    = OPCODE_LENGTH'(6'b100000);
    localparam logic [OPCODE_LENGTH-1:0] OP_LW    = OPCODE_LENGTH'(6'b100011);
    localparam logic [OPCODE_LENGTH-1:0] OP_SB    = OPCODE_LENGTH'(6'b101000);
    localparam logic [OPCODE_LENGTH-1:0] OP_SW    = OPCODE_LENGTH'(6'b101011);

    // R-type funct codes
    localparam logic [FUNCT_LENGTH-1:0] F_SLL     = FUNCT_LENGTH'(6'b000000);
    localparam logic [FUNCT_LENGTH-1:0] F_SRL     = FUNCT_LENGTH'(6'b000010);
    localparam logic [FUNCT_LENGTH-1:0] F_SRA     = FUNCT_LENGTH'(6'b000011);
    localparam logic [FUNCT_LENGTH-1:0] F_JR      = FUNCT_LENGTH'(6'b001000);
    localparam logic [FUNCT_LENGTH-1:0] F_SYSCALL = FUNCT_LENGTH'(6'b001100);
    localparam logic [FUNCT_LENGTH-1:0] F_ADD     = FUNCT_LENGTH'(6'b100000);
    localparam logic [FUNCT_LENGTH-1:0] F_ADDU    = FUNCT_LENGTH'(6'b100001);
    localparam logic [FUNCT_LENGTH-1:0] F_SUB     = FUNCT_LENGTH'(6'b100010);
    localparam logic [FUNCT_LENGTH-1:0] F_SUBU    = FUNCT_LENGTH'(6'b100011);
    localparam logic [FUNCT_LENGTH-1:0] F_AND     = FUNCT_LENGTH'(6'b100100);
    localparam logic [FUNCT_LENGTH-1:0] F_OR      = FUNCT_LENGTH'(6'b100101);
    localparam logic [FUNCT_LENGTH-1:0] F_XOR     = FUNCT_LENGTH'(6'b100110);
    localparam logic [FUNCT_LENGTH-1:0] F_NOR     = FUNCT_LENGTH'(6'b100111);
    localparam logic [FUNCT_LENGTH-1:0] F_SLT     = FUNCT_LENGTH'(6'b101010);
    localparam logic [FUNCT_LENGTH-1:0] F_SLTU    = FUNCT_LENGTH'(6'b101011);

    // The memory wait gives up on the cycle that would bring the wait count to MEM_TIMEOUT.
    localparam logic [TIMER_WIDTH-1:0] WAIT_LAST = TIMER_WIDTH'(MEM_TIMEOUT - 1);

    state_t                 cur;
    logic [TIMER_WIDTH-1:0] wait_cnt;
    logic                   timeout;

    // Instruction class and EXECUTE-phase encodings
    logic       legal, is_rtype, is_syscall, is_load, is_store, is_lbsb, is_ctl, is_jal;
    logic [3:0] ex_alu_op;
    logic [1:0] ex_alu_src;
    logic       ex_extend;
    logic [2:0] ex_branch;
    logic [1:0] ex_jump;
    logic       ex_jr;

    assign state   = cur;
    assign timeout = !mem_ready && (wait_cnt == WAIT_LAST);

    // Decode opcode/func into instruction class and single-cycle EXECUTE encodings
    always_comb begin
        legal      = 1'b1;
        is_rtype   = 1'b0;
        is_syscall = 1'b0;
        is_load    = 1'b0;
        is_store   = 1'b0;
        is_lbsb    = 1'b0;
        is_ctl     = 1'b0;
        is_jal     = 1'b0;
        ex_alu_op  = 4'b0000;
        ex_alu_src = 2'b00;
        ex_extend  = 1'b1;
        ex_branch  = 3'b000;
        ex_jump    = 2'b00;
        ex_jr      = 1'b0;
        case (opcode)
            OP_RTYPE: begin
                is_rtype = 1'b1;
                case (func)
                    F_ADD:              ex_alu_op = 4'b0001;
                    F_ADDU:             ex_alu_op = 4'b0010;
                    F_AND:              ex_alu_op = 4'b0011;
                    F_XOR:              ex_alu_op = 4'b0100;
                    F_OR:               ex_alu_op = 4'b0101;
                    F_SLT:              ex_alu_op = 4'b0110;
                    F_SUB, F_SUBU:      ex_alu_op = 4'b1000;
                    F_NOR:              ex_alu_op = 4'b1001;
                    F_SLTU:             ex_alu_op = 4'b1010;
                    F_SLL, F_SRL, F_SRA: ex_alu_src = 2'b01;
                    F_JR: begin
                        ex_jr  = 1'b1;
                        is_ctl = 1'b1;
                    end
                    F_SYSCALL:          is_syscall = 1'b1;
                    default: ;
                endcase
            end
            OP_ADDI:  begin ex_alu_op = 4'b0001; ex_alu_src = 2'b10; end
            OP_ADDIU: begin ex_alu_op = 4'b0010; ex_alu_src = 2'b10; ex_extend = 1'b0; end
            OP_ANDI:  begin ex_alu_op = 4'b0011; ex_alu_src = 2'b10; ex_extend = 1'b0; end
            OP_XORI:  begin ex_alu_op = 4'b0100; ex_alu_src = 2'b10; ex_extend = 1'b0; end
            OP_ORI:   begin ex_alu_op = 4'b0101; ex_alu_src = 2'b10; ex_extend = 1'b0; end
            OP_SLTI:  begin ex_alu_op = 4'b0110; ex_alu_src = 2'b10; end
            OP_LUI:   begin ex_alu_op = 4'b0111; ex_alu_src = 2'b10; end
            OP_BEQ:   begin ex_alu_op = 4'b1000; ex_branch = 3'b100; is_ctl = 1'b1; end
            OP_BNE:   begin ex_alu_op = 4'b1000; ex_branch = 3'b101; is_ctl = 1'b1; end
            OP_BLEZ:  begin ex_alu_op = 4'b1000; ex_branch = 3'b110; is_ctl = 1'b1; end
            OP_BGTZ:  begin ex_alu_op = 4'b1000; ex_branch = 3'b111; is_ctl = 1'b1; end
            OP_J:     begin ex_jump = 2'b01; is_ctl = 1'b1; end
            OP_JAL:   begin ex_jump = 2'b10; is_ctl = 1'b1; is_jal = 1'b1; end
            OP_LW:    begin ex_alu_op = 4'b0001; ex_alu_src = 2'b10; is_load = 1'b1; end
            OP_LB:    begin ex_alu_op = 4'b0001; ex_alu_src = 2'b10; is_load = 1'b1; is_lbsb = 1'b1; end
            OP_SW:    begin ex_alu_op = 4'b0001; ex_alu_src = 2'b10; is_store = 1'b1; end
            OP_SB:    begin ex_alu_op = 4'b0001; ex_alu_src = 2'b10; is_store = 1'b1; is_lbsb = 1'b1; end
            default:  legal = 1'b0;
        endcase
    end

    // Datapath controls from current state; held at reset values while rst is high
    always_comb begin
        mem_req    = 1'b0;
        ir_write   = 1'b0;
        pc_write   = 1'b0;
        reg_dst    = 1'b0;
        mem_to_reg = 1'b0;
        reg_write  = 1'b0;
        mem_read   = 1'b0;
        mem_write  = 1'b0;
        jr         = 1'b0;
        do_extend  = 1'b1;
        is_LB_SB   = 1'b0;
        alu_src    = 2'b00;
        alu_op     = 4'b0000;
        branch     = 3'b000;
        jump       = 2'b00;
        if (!rst) begin
            case (cur)
                S_FETCH: begin
                    mem_req  = 1'b1;
                    mem_read = 1'b1;
                    ir_write = mem_ready;
                    pc_write = mem_ready;
                end
                S_EXECUTE: begin
                    alu_src   = ex_alu_src;
                    alu_op    = ex_alu_op;
                    do_extend = ex_extend;
                    branch    = ex_branch;
                    jump      = ex_jump;
                    jr        = ex_jr;
                    reg_write = is_jal;
                end
                S_MEM: begin
                    mem_req   = 1'b1;
                    alu_op    = 4'b0001;
                    alu_src   = 2'b10;
                    mem_read  = is_load;
                    mem_write = is_store;
                    is_LB_SB  = is_lbsb;
                end
                S_WRITEBACK: begin
                    reg_write  = 1'b1;
                    reg_dst    = is_rtype;
                    mem_to_reg = is_load;
                    is_LB_SB   = is_load & is_lbsb;
                end
                default: ;
            endcase
        end
    end

    // Sequencer: state, memory wait counter and sticky halt/fault status
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cur      <= S_FETCH;
            wait_cnt <= '0;
            halted   <= 1'b0;
            fault    <= FLT_NONE;
        end else begin
            case (cur)
                S_FETCH: begin
                    if (mem_ready) begin
                        cur      <= S_DECODE;
                        wait_cnt <= '0;
                    end else if (timeout) begin
                        cur      <= S_HALT;
                        wait_cnt <= '0;
                        halted   <= 1'b1;
                        fault    <= FLT_TIMEOUT;
                    end else begin
                        wait_cnt <= wait_cnt + TIMER_WIDTH'(1);
                    end
                end
                S_DECODE: begin
                    if (!legal) begin
                        cur    <= S_HALT;
                        halted <= 1'b1;
                        fault  <= FLT_ILLEGAL;
                    end else if (is_syscall) begin
                        cur    <= S_HALT;
                        halted <= 1'b1;
                    end else begin
                        cur <= S_EXECUTE;
                    end
                end
                S_EXECUTE: begin
                    if (is_ctl)                  cur <= S_FETCH;
                    else if (is_load || is_store) cur <= S_MEM;
                    else                         cur <= S_WRITEBACK;
                end
                S_MEM: begin
                    if (mem_ready) begin
                        cur      <= is_load ? S_WRITEBACK : S_FETCH;
                        wait_cnt <= '0;
                    end else if (timeout) begin
                        cur      <= S_HALT;
                        wait_cnt <= '0;
                        halted   <= 1'b1;
                        fault    <= FLT_TIMEOUT;
                    end else begin
                        wait_cnt <= wait_cnt + TIMER_WIDTH'(1);
                    end
                end
                S_WRITEBACK: cur <= S_FETCH;
                S_HALT:      cur <= S_HALT;
                default:     cur <= S_FETCH;
            endcase
        end
    end

endmodule

// File: tb/tb_multicycle_control.sv
// Testbench for multicycle_control: table of instructions with their
// expected EXECUTE encodings, an expected-phase schedule built from the
// instruction latency rules, randomized memory waits, and hand-written
// sequences for halt, timeout and mid-access reset.
module tb_multicycle_control;

    localparam int C_ALU = 0, C_CTL = 1, C_LD = 2, C_ST = 3;
    localparam int P_F = 0, P_D = 1, P_E = 2, P_M = 3, P_W = 4, P_H = 5;

    typedef struct {
        logic [5:0] op;
        logic [5:0] fn;
        int         cls;
        bit         rt;
        bit         lbsb;
        bit         jal;
        bit         jrb;
        bit         ext;
        logic [3:0] aop;
        logic [1:0] src;
        logic [2:0] br;
        logic [1:0] jmp;
    } vec_t;

    logic clk = 1'b0;
    logic rst = 1'b0;
    logic [5:0] opcode = '0;
    logic [5:0] func = '0;
    logic mem_ready = 1'b0;
    logic mem_req, ir_write, pc_write, reg_dst, mem_to_reg, reg_write;
    logic mem_read, mem_write, jr, do_extend, is_LB_SB, halted;
    logic [1:0] alu_src, jump, fault;
    logic [3:0] alu_op;
    logic [2:0] branch, state;

    int checks = 0;
    int errors = 0;
    vec_t tab[22];
    logic [2:0] prev_pulse = '0;

    always #5 clk = ~clk;

    multicycle_control #(
        .OPCODE_LENGTH(6), .FUNCT_LENGTH(6), .MEM_TIMEOUT(15), .TIMER_WIDTH(8)
    ) dut (
        .clk(clk), .rst(rst), .opcode(opcode), .func(func), .mem_ready(mem_ready),
        .mem_req(mem_req), .ir_write(ir_write), .pc_write(pc_write), .reg_dst(reg_dst),
        .mem_to_reg(mem_to_reg), .reg_write(reg_write), .mem_read(mem_read),
        .mem_write(mem_write), .jr(jr), .do_extend(do_extend), .is_LB_SB(is_LB_SB),
        .alu_src(alu_src), .alu_op(alu_op), .branch(branch), .jump(jump),
        .halted(halted), .fault(fault), .state(state)
    );

    logic [24:0] act;
    assign act = {mem_req, ir_write, pc_write, reg_dst, mem_to_reg, reg_write, mem_read,
                  mem_write, jr, do_extend, is_LB_SB, alu_src, alu_op, branch, jump,
                  halted, fault};

    localparam logic [24:0] RST_VEC = {9'b0, 1'b1, 15'b0};

    function automatic logic [24:0] halt_vec(input logic [1:0] f);
        return {9'b0, 1'b1, 12'b0, 1'b1, f};
    endfunction

    function automatic vec_t mk(input logic [5:0] op, input logic [5:0] fn, input int cls,
                                input bit rt, input bit lbsb, input bit jal, input bit jrb,
                                input bit ext, input logic [3:0] aop, input logic [1:0] src,
                                input logic [2:0] br, input logic [1:0] jmp);
        vec_t v;
        v.op = op; v.fn = fn; v.cls = cls; v.rt = rt; v.lbsb = lbsb; v.jal = jal;
        v.jrb = jrb; v.ext = ext; v.aop = aop; v.src = src; v.br = br; v.jmp = jmp;
        return v;
    endfunction

    task automatic chk(input string nm, input logic [31:0] a, input logic [31:0] e);
        checks++;
        if (a !== e) begin
            errors++;
            $display("FAIL %s got=%0h want=%0h", nm, a, e);
        end
    endtask

    // Assert reset away from the clock edge, check reset values, release after one edge
    task automatic do_reset;
        rst = 1'b1;
        mem_ready = 1'b0;
        #1;
        chk("rst_vec", act, RST_VEC);
        chk("rst_state", state, P_F);
        @(posedge clk); #1;
        rst = 1'b0;
        prev_pulse = '0;
    endtask

    // One cycle with a given mem_ready, checking only the state
    task automatic cyc(input logic r, input int st, input string nm);
        mem_ready = r;
        @(negedge clk);
        chk(nm, state, st);
        @(posedge clk); #1;
    endtask

    // Runs one instruction from FETCH. The expected phase list is built from
    // latency rules: FETCH (fw waits), DECODE, EXECUTE, MEM (mw waits) for
    // loads/stores, WRITEBACK for ALU ops and loads.
    task automatic run_instr(input int idx, input int fw, input int mw);
        int   ph[$];
        bit   rq[$];
        vec_t v;
        bit   ld, st;
        string nm;
        v  = tab[idx];
        ld = (v.cls == C_LD);
        st = (v.cls == C_ST);
        for (int k = 0; k <= fw; k++) begin ph.push_back(P_F); rq.push_back(k == fw); end
        ph.push_back(P_D); rq.push_back(1'($urandom % 2));
        ph.push_back(P_E); rq.push_back(1'($urandom % 2));
        if (ld || st)
            for (int k = 0; k <= mw; k++) begin ph.push_back(P_M); rq.push_back(k == mw); end
        if (v.cls == C_ALU || ld) begin ph.push_back(P_W); rq.push_back(1'($urandom % 2)); end
        opcode = v.op;
        func   = v.fn;
        for (int i = 0; i < ph.size(); i++) begin
            int p;
            bit r;
            logic [24:0] e;
            logic [2:0]  pulse;
            p = ph[i];
            r = rq[i];
            mem_ready = r;
            @(negedge clk);
            nm = $sformatf("op%02h_fn%02h_c%0d", v.op, v.fn, i);
            chk({nm, "_state"}, state, p);
            e = {(p == P_F || p == P_M),
                 (p == P_F && r),
                 (p == P_F && r),
                 (p == P_W && v.rt),
                 (p == P_W && ld),
                 (p == P_W || (p == P_E && v.jal)),
                 (p == P_F || (p == P_M && ld)),
                 (p == P_M && st),
                 (p == P_E && v.jrb),
                 ((p == P_E) ? v.ext : 1'b1),
                 ((p == P_M && v.lbsb) || (p == P_W && ld && v.lbsb)),
                 ((p == P_E) ? v.src : (p == P_M) ? 2'b10 : 2'b00),
                 ((p == P_E) ? v.aop : (p == P_M) ? 4'b0001 : 4'b0000),
                 ((p == P_E) ? v.br : 3'b000),
                 ((p == P_E) ? v.jmp : 2'b00),
                 3'b000};
            chk({nm, "_ctl"}, act, e);
            pulse = {ir_write, pc_write, reg_write};
            chk({nm, "_b2b"}, pulse & prev_pulse, 0);
            prev_pulse = pulse;
            @(posedge clk); #1;
        end
    endtask

    initial begin
        //             op         fn         cls    rt lb jal jr ext aop      src    br      jmp
        tab[0]  = mk(6'b001000, 6'h2a,     C_ALU, 0, 0, 0, 0, 1, 4'b0001, 2'b10, 3'b000, 2'b00); // addi
        tab[1]  = mk(6'b001001, 6'h2a,     C_ALU, 0, 0, 0, 0, 0, 4'b0010, 2'b10, 3'b000, 2'b00); // addiu
        tab[2]  = mk(6'b001100, 6'h2a,     C_ALU, 0, 0, 0, 0, 0, 4'b0011, 2'b10, 3'b000, 2'b00); // andi
        tab[3]  = mk(6'b001110, 6'h2a,     C_ALU, 0, 0, 0, 0, 0, 4'b0100, 2'b10, 3'b000, 2'b00); // xori
        tab[4]  = mk(6'b001101, 6'h2a,     C_ALU, 0, 0, 0, 0, 0, 4'b0101, 2'b10, 3'b000, 2'b00); // ori
        tab[5]  = mk(6'b001010, 6'h2a,     C_ALU, 0, 0, 0, 0, 1, 4'b0110, 2'b10, 3'b000, 2'b00); // slti
        tab[6]  = mk(6'b001111, 6'h2a,     C_ALU, 0, 0, 0, 0, 1, 4'b0111, 2'b10, 3'b000, 2'b00); // lui
        tab[7]  = mk(6'b000000, 6'b100000, C_ALU, 1, 0, 0, 0, 1, 4'b0001, 2'b00, 3'b000, 2'b00); // add
        tab[8]  = mk(6'b000000, 6'b100010, C_ALU, 1, 0, 0, 0, 1, 4'b1000, 2'b00, 3'b000, 2'b00); // sub
        tab[9]  = mk(6'b000000, 6'b100100, C_ALU, 1, 0, 0, 0, 1, 4'b0011, 2'b00, 3'b000, 2'b00); // and
        tab[10] = mk(6'b000000, 6'b000000, C_ALU, 1, 0, 0, 0, 1, 4'b0000, 2'b01, 3'b000, 2'b00); // sll
        tab[11] = mk(6'b000000, 6'b000010, C_ALU, 1, 0, 0, 0, 1, 4'b0000, 2'b01, 3'b000, 2'b00); // srl
        tab[12] = mk(6'b000000, 6'b001000, C_CTL, 1, 0, 0, 1, 1, 4'b0000, 2'b00, 3'b000, 2'b00); // jr
        tab[13] = mk(6'b000100, 6'h2a,     C_CTL, 0, 0, 0, 0, 1, 4'b1000, 2'b00, 3'b100, 2'b00); // beq
        tab[14] = mk(6'b000101, 6'h2a,     C_CTL, 0, 0, 0, 0, 1, 4'b1000, 2'b00, 3'b101, 2'b00); // bne
        tab[15] = mk(6'b000111, 6'h2a,     C_CTL, 0, 0, 0, 0, 1, 4'b1000, 2'b00, 3'b111, 2'b00); // bgtz
        tab[16] = mk(6'b000010, 6'h2a,     C_CTL, 0, 0, 0, 0, 1, 4'b0000, 2'b00, 3'b000, 2'b01); // j
        tab[17] = mk(6'b000011, 6'h2a,     C_CTL, 0, 0, 1, 0, 1, 4'b0000, 2'b00, 3'b000, 2'b10); // jal
        tab[18] = mk(6'b100011, 6'h2a,     C_LD,  0, 0, 0, 0, 1, 4'b0001, 2'b10, 3'b000, 2'b00); // lw
        tab[19] = mk(6'b100000, 6'h2a,     C_LD,  0, 1, 0, 0, 1, 4'b0001, 2'b10, 3'b000, 2'b00); // lb
        tab[20] = mk(6'b101011, 6'h2a,     C_ST,  0, 0, 0, 0, 1, 4'b0001, 2'b10, 3'b000, 2'b00); // sw
        tab[21] = mk(6'b101000, 6'h2a,     C_ST,  0, 1, 0, 0, 1, 4'b0001, 2'b10, 3'b000, 2'b00); // sb

        do_reset();

        // Every table entry with immediate memory response
        for (int i = 0; i < 22; i++) run_instr(i, 0, 0);

        // Random instruction mix with random fetch/memory waits
        for (int n = 0; n < 40; n++)
            run_instr(int'($urandom_range(0, 21)), int'($urandom_range(0, 3)),
                      int'($urandom_range(0, 3)));

        // LW with three wait cycles in MEM: F D E M M M M W
        run_instr(18, 0, 3);

        // Illegal opcode: HALT after DECODE, no memory traffic afterwards
        do_reset();
        opcode = 6'b111111; func = 6'b000000;
        cyc(1'b1, P_F, "ill_fetch");
        cyc(1'b0, P_D, "ill_decode");
        for (int k = 0; k < 21; k++) begin
            mem_ready = 1'($urandom % 2);
            @(negedge clk);
            chk($sformatf("ill_halt_state_%0d", k), state, P_H);
            chk($sformatf("ill_halt_vec_%0d", k), act, halt_vec(2'b01));
            @(posedge clk); #1;
        end

        // SYSCALL: HALT with no fault
        do_reset();
        opcode = 6'b000000; func = 6'b001100;
        cyc(1'b1, P_F, "sys_fetch");
        cyc(1'b0, P_D, "sys_decode");
        mem_ready = 1'b0;
        @(negedge clk);
        chk("sys_state", state, P_H);
        chk("sys_vec", act, halt_vec(2'b00));
        @(posedge clk); #1;

        // FETCH timeout: 15 cycles without ready, HALT visible on the 16th
        do_reset();
        for (int k = 1; k <= 15; k++) cyc(1'b0, P_F, $sformatf("to_wait_%0d", k));
        mem_ready = 1'b0;
        @(negedge clk);
        chk("to_state", state, P_H);
        chk("to_vec", act, halt_vec(2'b10));
        @(posedge clk); #1;

        // Ready arriving on the 15th FETCH cycle still succeeds
        do_reset();
        opcode = 6'b001000; func = 6'h2a;
        for (int k = 1; k <= 14; k++) cyc(1'b0, P_F, $sformatf("edge_wait_%0d", k));
        cyc(1'b1, P_F, "edge_last");
        mem_ready = 1'b0;
        @(negedge clk);
        chk("edge_state", state, P_D);
        chk("edge_fault", {halted, fault}, 3'b000);
        @(posedge clk); #1;

        // MEM timeout on a load
        do_reset();
        opcode = 6'b100011; func = 6'h2a;
        cyc(1'b1, P_F, "mto_fetch");
        cyc(1'b0, P_D, "mto_decode");
        cyc(1'b0, P_E, "mto_exec");
        for (int k = 1; k <= 15; k++) cyc(1'b0, P_M, $sformatf("mto_wait_%0d", k));
        mem_ready = 1'b0;
        @(negedge clk);
        chk("mto_vec", act, halt_vec(2'b10));
        @(posedge clk); #1;

        // SB waiting in MEM, reset asserted mid-cycle drops mem_write at once
        do_reset();
        opcode = 6'b101000; func = 6'h2a;
        cyc(1'b1, P_F, "sbr_fetch");
        cyc(1'b0, P_D, "sbr_decode");
        cyc(1'b0, P_E, "sbr_exec");
        cyc(1'b0, P_M, "sbr_mem1");
        mem_ready = 1'b0;
        @(negedge clk);
        chk("sbr_mem_write", mem_write, 1);
        rst = 1'b1;
        #1;
        chk("sbr_rst_vec", act, RST_VEC);
        chk("sbr_rst_state", state, P_F);
        @(posedge clk); #1;
        rst = 1'b0;
        prev_pulse = '0;
        run_instr(7, 1, 0);
        run_instr(21, 0, 2);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
